obstacle_guard: RTL

Safety stage directly downstream of the IR obstacle sensor. It consumes the active-high `obstacles_` level, synchronizes and debounces it, and gates the motion command coming from the cart controller before it reaches the motor driver. When an obstacle is confirmed while the cart is driving forward, it runs a fixed brake / back-off sequence. Otherwise it passes the command through with one cycle of latency.

---
 rtl/cart_pkg.sv | 16 +
 rtl/obstacle_debounce.sv | 38 +++
 rtl/obstacle_guard.sv | 114 +++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared cart definitions: motor mode encoding and the obstacle guard state set.
package cart_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_BWD  = 2'b10;
  localparam logic [1:0] MODE_SPIN = 2'b11;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_BRAKE   = 2'd1,
    ST_REVERSE = 2'd2,
    ST_HOLD    = 2'd3
  } guard_state_t;

endpackage

// File: rtl/obstacle_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for the IR obstacle level.
module obstacle_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             obs_s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      obs_s  <= 1'b0;
      dout   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= din;
      obs_s  <= sync_1;
      if (obs_s == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= ~dout;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/obstacle_guard.sv
// Gates cart motion commands; a confirmed obstacle while driving forward triggers
// a committed brake / back-off sequence.
//
//   state   | meaning
//   PASS    | command passes through with one cycle of latency
//   BRAKE   | STOP/0 for BRAKE_CYCLES cycles
//   REVERSE | BWD/REV_SPEED for REVERSE_CYCLES cycles
//   HOLD    | obstacle still present: FWD forced to STOP/0, other modes pass
module obstacle_guard
  import cart_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         BRAKE_CYCLES    = 10000000,
  parameter int         REVERSE_CYCLES  = 30000000,
  parameter logic [9:0] REV_SPEED       = 10'd300,
  parameter int         CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       obstacles_,
  input  logic [1:0] mode_in,
  input  logic [9:0] speed_in,
  output logic [1:0] mode_out,
  output logic [9:0] speed_out,
  output logic       blocked,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] BRAKE_LAST   = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REVERSE_LAST = CNT_W'(REVERSE_CYCLES - 1);

  logic             obs_db;
  guard_state_t     state;
  logic [CNT_W-1:0] dwell;

  obstacle_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (obstacles_),
    .dout(obs_db)
  );

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_PASS;
      dwell     <= '0;
      mode_out  <= MODE_STOP;
      speed_out <= '0;
      blocked   <= 1'b0;
    end else begin
      case (state)
        ST_PASS: begin
          if (obs_db && mode_in == MODE_FWD) begin
            state     <= ST_BRAKE;
            dwell     <= '0;
            mode_out  <= MODE_STOP;
            speed_out <= '0;
            blocked   <= 1'b1;
          end else begin
            mode_out  <= mode_in;
            speed_out <= speed_in;
            blocked   <= 1'b0;
          end
        end
        ST_BRAKE: begin
          if (dwell == BRAKE_LAST) begin
            state     <= ST_REVERSE;
            dwell     <= '0;
            mode_out  <= MODE_BWD;
            speed_out <= REV_SPEED;
          end else begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        ST_REVERSE: begin
          if (dwell == REVERSE_LAST) begin
            dwell <= '0;
            // Routing uses the debounced level as it stood before this edge.
            if (obs_db) begin
              state     <= ST_HOLD;
              mode_out  <= (mode_in == MODE_FWD) ? MODE_STOP : mode_in;
              speed_out <= (mode_in == MODE_FWD) ? 10'd0 : speed_in;
            end else begin
              state     <= ST_PASS;
              mode_out  <= mode_in;
              speed_out <= speed_in;
              blocked   <= 1'b0;
            end
          end else begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!obs_db) begin
            state     <= ST_PASS;
            mode_out  <= mode_in;
            speed_out <= speed_in;
            blocked   <= 1'b0;
          end else begin
            mode_out  <= (mode_in == MODE_FWD) ? MODE_STOP : mode_in;
            speed_out <= (mode_in == MODE_FWD) ? 10'd0 : speed_in;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

endmodule
